// File: rtl/uart_mem_host.sv
// uart_mem_host: serial initiator for a UART memory target.
// Turns a single-outstanding parallel read/write request into cmd/addr(/data)
// frames on TX and, for reads, receives one response frame on RX.
module uart_mem_host #(
  parameter int ADDR_WIDTH     = 2,
  parameter int DATA_WIDTH     = 2,
  parameter int BAUD_PERIOD    = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  TX,
  input  logic                  RX
);

  localparam int BCW = (BAUD_PERIOD > 1) ? $clog2(BAUD_PERIOD) : 1;
  localparam int BIW = $clog2(ADDR_WIDTH + 2);
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BCW-1:0] BAUD_LAST     = BCW'(BAUD_PERIOD - 1);
  localparam logic [BCW-1:0] HALF_LAST     = BCW'(BAUD_PERIOD / 2 - 1);
  localparam logic [BIW-1:0] STOP_IDX      = BIW'(ADDR_WIDTH + 1);
  localparam logic [BIW-1:0] LAST_DATA_IDX = BIW'(ADDR_WIDTH);
  localparam logic [TOW-1:0] TO_LAST       = TOW'(TIMEOUT_CYCLES - 1);

  // Data must fit in one serial word and a bit must span at least two clocks.
  generate
    if (DATA_WIDTH > ADDR_WIDTH) begin : g_bad_data_width
      $error("uart_mem_host: DATA_WIDTH must be <= ADDR_WIDTH");
    end
    if (BAUD_PERIOD < 2) begin : g_bad_baud
      $error("uart_mem_host: BAUD_PERIOD must be >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE, SEND_CMD, SEND_ADDR, SEND_DATA, WAIT_RSP, RECV_DATA, DONE
  } state_t;

  state_t                state_r;
  logic                  wr_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [ADDR_WIDTH-1:0] tx_shift_r;
  logic [ADDR_WIDTH-1:0] rx_word_r;
  logic [BCW-1:0]        baud_cnt_r;
  logic [BIW-1:0]        bit_idx_r;
  logic [TOW-1:0]        to_cnt_r;
  logic                  rx_s1_r, rx_s2_r, rx_prev_r;

  logic [ADDR_WIDTH-1:0] cmd_word_s;
  logic [ADDR_WIDTH-1:0] data_word_s;
  logic [TOW-1:0]        to_next_s;
  logic                  rx_fall_s;

  // Frame words and the saturating timeout increment.
  always_comb begin
    cmd_word_s                     = '0;
    cmd_word_s[0]                  = req_wr;
    data_word_s                    = '0;
    data_word_s[DATA_WIDTH-1:0]    = wdata_r;
    to_next_s = (to_cnt_r == TO_LAST) ? to_cnt_r : to_cnt_r + 1'b1;
    rx_fall_s = rx_prev_r & ~rx_s2_r;
  end

  // Two-flop RX synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rx_s1_r   <= 1'b1;
      rx_s2_r   <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_s1_r   <= RX;
      rx_s2_r   <= rx_s1_r;
      rx_prev_r <= rx_s2_r;
    end
  end

  // Transaction FSM: serializes request frames, receives the read reply.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_r    <= IDLE;
      wr_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      tx_shift_r <= '0;
      rx_word_r  <= '0;
      baud_cnt_r <= '0;
      bit_idx_r  <= '0;
      to_cnt_r   <= '0;
      TX         <= 1'b1;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            wr_r       <= req_wr;
            addr_r     <= req_addr;
            wdata_r    <= req_wdata;
            tx_shift_r <= cmd_word_s;
            TX         <= 1'b0;
            baud_cnt_r <= '0;
            bit_idx_r  <= '0;
            req_ready  <= 1'b0;
            state_r    <= SEND_CMD;
          end
        end
        SEND_CMD, SEND_ADDR, SEND_DATA: begin
          if (baud_cnt_r != BAUD_LAST) begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
          end else begin
            baud_cnt_r <= '0;
            if (bit_idx_r != STOP_IDX) begin
              bit_idx_r <= bit_idx_r + 1'b1;
              if (bit_idx_r != LAST_DATA_IDX) begin
                TX         <= tx_shift_r[0];
                tx_shift_r <= tx_shift_r >> 1;
              end else begin
                TX <= 1'b1;
              end
            end else begin
              // Stop bit finished: start the next frame back-to-back.
              bit_idx_r <= '0;
              if (state_r == SEND_CMD) begin
                TX         <= 1'b0;
                tx_shift_r <= addr_r;
                state_r    <= SEND_ADDR;
              end else if (state_r == SEND_ADDR && wr_r) begin
                TX         <= 1'b0;
                tx_shift_r <= data_word_s;
                state_r    <= SEND_DATA;
              end else if (state_r == SEND_ADDR) begin
                to_cnt_r <= '0;
                state_r  <= WAIT_RSP;
              end else begin
                rsp_valid <= 1'b1;
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
                state_r   <= DONE;
              end
            end
          end
        end
        WAIT_RSP: begin
          if (rx_fall_s) begin
            to_cnt_r   <= to_next_s;
            baud_cnt_r <= '0;
            bit_idx_r  <= '0;
            state_r    <= RECV_DATA;
          end else if (to_cnt_r == TO_LAST) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            state_r   <= DONE;
          end else begin
            to_cnt_r <= to_next_s;
          end
        end
        RECV_DATA: begin
          to_cnt_r <= to_next_s;
          if (bit_idx_r == '0) begin
            // Mid start bit: a high sample means the edge was a glitch.
            if (baud_cnt_r == HALF_LAST) begin
              baud_cnt_r <= '0;
              if (rx_s2_r) begin
                state_r <= WAIT_RSP;
              end else begin
                bit_idx_r <= 1'b1;
              end
            end else begin
              baud_cnt_r <= baud_cnt_r + 1'b1;
            end
          end else if (baud_cnt_r == BAUD_LAST) begin
            baud_cnt_r <= '0;
            if (bit_idx_r == STOP_IDX) begin
              rsp_valid <= 1'b1;
              rsp_err   <= ~rx_s2_r;
              rsp_rdata <= rx_s2_r ? rx_word_r[DATA_WIDTH-1:0] : '0;
              bit_idx_r <= '0;
              state_r   <= DONE;
            end else begin
              rx_word_r                 <= rx_word_r >> 1;
              rx_word_r[ADDR_WIDTH-1]   <= rx_s2_r;
              bit_idx_r                 <= bit_idx_r + 1'b1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
          end
        end
        DONE: begin
          req_ready <= 1'b1;
          state_r   <= IDLE;
        end
        default: begin
          TX        <= 1'b1;
          req_ready <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_host.sv
// Directed self-checking bench for uart_mem_host with default parameters
// (2-bit words, 3 clocks per bit, 12-clock frames, 64-clock read timeout).
module tb_uart_mem_host;

  logic       clk;
  logic       rst_l;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [1:0] req_addr;
  logic [1:0] req_wdata;
  logic       rsp_valid;
  logic [1:0] rsp_rdata;
  logic       rsp_err;
  logic       TX;
  logic       RX;

  int checks   = 0;
  int failures = 0;

  uart_mem_host dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .TX        (TX),
    .RX        (RX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present a request; returns just after the accepting edge (cycle 1).
  task automatic start_req(input logic wr, input logic [1:0] addr, input logic [1:0] wdata);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_eq("ready_drop", req_ready, 32'd0);
  endtask

  // seq lists the four bit values in transmit order, first bit in seq[3].
  task automatic check_frame(input string tag, input logic [3:0] seq);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      check_eq($sformatf("%s_bit%0d", tag, b), TX, seq[3-b]);
      repeat (3) @(posedge clk);
    end
  endtask

  // Target model: wait gap clocks, then drive a frame (first bit in seq[3]).
  task automatic send_rx_frame(input int gap, input logic [3:0] seq);
    repeat (gap) @(posedge clk);
    for (int b = 0; b < 4; b++) begin
      #1 RX = seq[3-b];
      repeat (3) @(posedge clk);
    end
    #1 RX = 1'b1;
  endtask

  // Bounded wait for rsp_valid; leaves on the negedge where it is seen.
  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 200) begin
      n++;
      @(negedge clk);
    end
    check_eq({tag, "_rsp_seen"}, rsp_valid, 32'd1);
  endtask

  // Count high samples of rsp_valid and low samples of TX over n cycles.
  task automatic count_activity(input int n, output int valids, output int tx_lows);
    valids  = 0;
    tx_lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rsp_valid) valids++;
      if (!TX) tx_lows++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int valids;
    int tx_lows;
    int busy_ready;

    rst_l     = 1'b0;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = 2'd0;
    req_wdata = 2'd0;
    RX        = 1'b1;

    // Reset values.
    repeat (3) @(negedge clk);
    check_eq("rst_tx", TX, 32'd1);
    check_eq("rst_ready", req_ready, 32'd1);
    check_eq("rst_valid", rsp_valid, 32'd0);
    check_eq("rst_rdata", rsp_rdata, 32'd0);
    check_eq("rst_err", rsp_err, 32'd0);
    rst_l = 1'b1;

    // Idle with no request.
    busy_ready = 0;
    valids     = 0;
    tx_lows    = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!req_ready) busy_ready++;
      if (rsp_valid) valids++;
      if (!TX) tx_lows++;
    end
    check_eq("idle_ready_low", busy_ready, 32'd0);
    check_eq("idle_valid", valids, 32'd0);
    check_eq("idle_tx_low", tx_lows, 32'd0);

    // Write addr=2 data=3.
    start_req(1'b1, 2'd2, 2'd3);
    check_frame("wr_cmd", 4'b0101);
    check_frame("wr_addr", 4'b0011);
    check_frame("wr_data", 4'b0111);
    @(negedge clk);
    check_eq("wr_valid", rsp_valid, 32'd1);
    check_eq("wr_err", rsp_err, 32'd0);
    check_eq("wr_rdata", rsp_rdata, 32'd0);
    check_eq("wr_ready_in_done", req_ready, 32'd0);
    @(negedge clk);
    check_eq("wr_valid_pulse", rsp_valid, 32'd0);
    check_eq("wr_ready_back", req_ready, 32'd1);

    // Read addr=1, target replies word 2 four clocks after the addr frame.
    start_req(1'b0, 2'd1, 2'd0);
    check_frame("rd_cmd", 4'b0001);
    check_frame("rd_addr", 4'b0101);
    send_rx_frame(4, 4'b0011);
    wait_rsp("rd");
    check_eq("rd_rdata", rsp_rdata, 32'd2);
    check_eq("rd_err", rsp_err, 32'd0);

    // Read with RX idle: timeout 64 clocks after the addr stop bit.
    repeat (3) @(posedge clk);
    start_req(1'b0, 2'd3, 2'd0);
    check_frame("to_cmd", 4'b0001);
    check_frame("to_addr", 4'b0111);
    repeat (63) @(posedge clk);
    @(negedge clk);
    check_eq("to_early", rsp_valid, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq("to_valid", rsp_valid, 32'd1);
    check_eq("to_err", rsp_err, 32'd1);
    check_eq("to_rdata", rsp_rdata, 32'd0);

    // One-clock RX glitch is rejected; later frame (word 1) completes.
    repeat (3) @(posedge clk);
    start_req(1'b0, 2'd0, 2'd0);
    check_frame("gl_cmd", 4'b0001);
    check_frame("gl_addr", 4'b0001);
    repeat (5) @(posedge clk);
    #1 RX = 1'b0;
    @(posedge clk);
    #1 RX = 1'b1;
    count_activity(10, valids, tx_lows);
    check_eq("gl_no_rsp", valids, 32'd0);
    send_rx_frame(0, 4'b0101);
    wait_rsp("gl");
    check_eq("gl_rdata", rsp_rdata, 32'd1);
    check_eq("gl_err", rsp_err, 32'd0);

    // req_valid held while busy: accepted once now, once more in IDLE.
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 2'd3;
    req_wdata = 2'd1;
    @(posedge clk);
    busy_ready = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (req_ready) busy_ready++;
    end
    check_eq("held_busy_ready", busy_ready, 32'd0);
    wait_rsp("held1");
    check_eq("held1_err", rsp_err, 32'd0);
    @(negedge clk);
    check_eq("held_ready_back", req_ready, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check_eq("held2_start_tx", TX, 32'd0);
    check_eq("held2_ready", req_ready, 32'd0);
    count_activity(60, valids, tx_lows);
    check_eq("held2_rsp_count", valids, 32'd1);
    count_activity(20, valids, tx_lows);
    check_eq("held_no_third_tx", tx_lows, 32'd0);
    check_eq("held_no_third_rsp", valids, 32'd0);

    // Reply with stop bit 0 gives a framing error.
    start_req(1'b0, 2'd2, 2'd0);
    check_frame("fe_cmd", 4'b0001);
    check_frame("fe_addr", 4'b0011);
    send_rx_frame(4, 4'b0110);
    wait_rsp("fe");
    check_eq("fe_err", rsp_err, 32'd1);
    check_eq("fe_rdata", rsp_rdata, 32'd0);

    // Reset pulsed during the addr frame of a write.
    repeat (3) @(posedge clk);
    start_req(1'b1, 2'd2, 2'd3);
    check_frame("rs_cmd", 4'b0101);
    @(negedge clk);
    check_eq("rs_pre_tx", TX, 32'd0);
    #1 rst_l = 1'b0;
    #1;
    check_eq("rs_async_tx", TX, 32'd1);
    check_eq("rs_ready", req_ready, 32'd1);
    check_eq("rs_err_clr", rsp_err, 32'd0);
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    count_activity(50, valids, tx_lows);
    check_eq("rs_no_rsp", valids, 32'd0);
    check_eq("rs_tx_idle", tx_lows, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
